// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential execute-stage ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SLT = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRL = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SRA = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // One bit per operation code; set for codes handled by the iterative shifter.
  localparam logic [15:0] ALU_SHIFT_OPS = 16'h02C0;

endpackage

// File: rtl/alu_iter_shifter.sv
// One-bit-per-cycle shifter: shift register plus down-counter, started by the top FSM.
module alu_iter_shifter
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [SHAMT_W-1:0]    amt,
  output logic                  done_c,
  output logic [DATA_WIDTH-1:0] result_c
);

  logic [DATA_WIDTH-1:0] sreg_q;
  logic [DATA_WIDTH-1:0] shifted;
  logic [SHAMT_W-1:0]    cnt_q;
  logic                  left_q;
  logic                  arith_q;

  // Arithmetic right shift keeps replicating the original sign bit.
  always_comb begin
    shifted = sreg_q;
    if (left_q) begin
      shifted = {sreg_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      shifted = {arith_q & sreg_q[DATA_WIDTH-1], sreg_q[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      sreg_q  <= data;
      cnt_q   <= amt;
      left_q  <= (op == OP_SLL);
      arith_q <= (op == OP_SRA);
    end else if (cnt_q != '0) begin
      sreg_q <= shifted;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

  // Final iteration: the value produced on this edge is the shift result.
  assign done_c   = (cnt_q == SHAMT_W'(1));
  assign result_c = shifted;

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready handshake; single-cycle ops plus an iterative shifter.
module alu_seq_exec
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  illegal_op
);

  alu_state_e            state_q, state_n;
  logic                  pend_q;
  alu_op_e               op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  illegal_q;
  logic                  out_valid_q;

  logic                  accept;
  logic                  is_shift;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_c;
  logic                  alu_ill_c;
  logic                  ld_res_c;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  ill_d;
  logic                  sh_start_c;
  logic                  sh_done_c;
  logic [DATA_WIDTH-1:0] sh_result_c;

  // Capture happens on the accept edge; evaluation follows from the captured operands.
  assign in_ready = rst_n && (state_q == ST_IDLE) && !pend_q;
  assign accept   = in_valid && in_ready;
  assign is_shift = ALU_SHIFT_OPS[4'(op_q)];
  assign shamt    = b_q[SHAMT_W-1:0];

  always_comb begin
    alu_c     = '0;
    alu_ill_c = 1'b0;
    case (op_q)
      OP_AND:  alu_c = a_q & b_q;
      OP_OR:   alu_c = a_q | b_q;
      OP_ADD:  alu_c = a_q + b_q;
      OP_XOR:  alu_c = a_q ^ b_q;
      OP_SUB:  alu_c = a_q - b_q;
      OP_SLT:  alu_c = DATA_WIDTH'($signed(a_q) < $signed(b_q));
      OP_BEQ:  alu_c = DATA_WIDTH'(a_q == b_q);
      OP_SLL, OP_SRL, OP_SRA: alu_c = '0;
      default: alu_ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    ld_res_c   = 1'b0;
    res_d      = result_q;
    ill_d      = illegal_q;
    sh_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          if (!is_shift) begin
            ld_res_c = 1'b1;
            res_d    = alu_c;
            ill_d    = alu_ill_c;
            state_n  = ST_DONE;
          end else if (shamt == '0) begin
            ld_res_c = 1'b1;
            res_d    = a_q;
            ill_d    = 1'b0;
            state_n  = ST_DONE;
          end else begin
            sh_start_c = 1'b1;
            state_n    = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_done_c) begin
          ld_res_c = 1'b1;
          res_d    = sh_result_c;
          ill_d    = 1'b0;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      pend_q      <= accept;
      out_valid_q <= (state_n == ST_DONE);
      if (accept) begin
        op_q <= alu_op_e'(Operation);
        a_q  <= SrcA;
        b_q  <= SrcB;
      end
      if (ld_res_c) begin
        result_q  <= res_d;
        illegal_q <= ill_d;
      end
    end
  end

  alu_iter_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .SHAMT_W   (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (sh_start_c),
    .op      (op_q),
    .data    (a_q),
    .amt     (shamt),
    .done_c  (sh_done_c),
    .result_c(sh_result_c)
  );

  assign out_valid  = out_valid_q;
  assign ALUResult  = result_q;
  assign Zero       = (result_q == '0);
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed table, random ops vs. model, hold and reset sequences.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written directly from the operation table.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int unsigned sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a ^ b;
      4'd4: r = a - b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: begin r = a << sh; lat = 1 + sh; end
      4'd7: begin r = a >> sh; lat = 1 + sh; end
      4'd8: r = (a == b) ? 32'd1 : 32'd0;
      4'd9: begin r = 32'($signed(a) >>> sh); lat = 1 + sh; end
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic eill,
                       input int elat, input int hold);
    int t;
    int lat;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 100);
    chk({name, " latency"}, 32'(lat), 32'(elat));
    chk({name, " result"}, ALUResult, er);
    chk({name, " zero"}, 32'(Zero), 32'(er == 32'd0));
    chk({name, " illegal"}, 32'(illegal_op), 32'(eill));
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      Operation = 4'(i);
      SrcA      = $urandom;
      SrcB      = $urandom;
      @(posedge clk); #1;
      chk({name, " hold valid"}, 32'(out_valid), 32'd1);
      chk({name, " hold result"}, ALUResult, er);
      chk({name, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, " handoff"}, 32'(out_valid), 32'd0);
    chk({name, " idle ready"}, 32'(in_ready), 32'd1);
    if (hold > 0) begin
      repeat (2) @(posedge clk);
      #1;
      chk({name, " nothing captured"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] er;
    logic        eill;
    int          elat;
    logic [3:0]  op;
    logic [31:0] a, b;

    tbl[0]  = '{4'h2, 32'd5,         32'd7,         32'd12,        1'b0, 1,  0};
    tbl[1]  = '{4'h4, 32'd7,         32'd7,         32'd0,         1'b0, 1,  0};
    tbl[2]  = '{4'h5, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1,  0};
    tbl[3]  = '{4'h8, 32'h1234,      32'h1234,      32'd1,         1'b0, 1,  0};
    tbl[4]  = '{4'h8, 32'd1,         32'd2,         32'd0,         1'b0, 1,  0};
    tbl[5]  = '{4'h9, 32'h80000000,  32'd4,         32'hF8000000,  1'b0, 5,  0};
    tbl[6]  = '{4'h7, 32'h80000000,  32'd4,         32'h08000000,  1'b0, 5,  0};
    tbl[7]  = '{4'h6, 32'd1,         32'd31,        32'h80000000,  1'b0, 32, 0};
    tbl[8]  = '{4'h6, 32'hDEADBEEF,  32'd0,         32'hDEADBEEF,  1'b0, 1,  0};
    tbl[9]  = '{4'hF, 32'h12345678,  32'h9,         32'd0,         1'b1, 1,  0};
    tbl[10] = '{4'h0, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1,  0};
    tbl[11] = '{4'h1, 32'hF0F0,      32'h0F0F,      32'hFFFF,      1'b0, 1,  0};
    tbl[12] = '{4'h3, 32'hFFFF0000,  32'hFF00FF00,  32'h00FFFF00,  1'b0, 1,  0};
    tbl[13] = '{4'h9, 32'h7FFFFFFF,  32'h21,        32'h3FFFFFFF,  1'b0, 2,  0};
    tbl[14] = '{4'h7, 32'hFFFFFFFF,  32'd31,        32'd1,         1'b0, 32, 0};
    tbl[15] = '{4'h2, 32'd100,       32'd23,        32'd123,       1'b0, 1,  3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Operation = 4'd0;
    SrcA      = '0;
    SrcB      = '0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", ALUResult, 32'd0);
    chk("reset zero", 32'(Zero), 32'd1);
    chk("reset illegal", 32'(illegal_op), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].res, tbl[i].ill, tbl[i].lat, tbl[i].hold);
    end

    do_op("illegal 1010", 4'hA, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b1, 1, 0);

    // Reset asserted in the middle of an SRL by 20.
    in_valid  = 1'b1;
    Operation = 4'h7;
    SrcA      = 32'h80000000;
    SrcB      = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midshift rst out_valid", 32'(out_valid), 32'd0);
    chk("midshift rst result", ALUResult, 32'd0);
    chk("midshift rst zero", 32'(Zero), 32'd1);
    chk("midshift rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after rst in_ready", 32'(in_ready), 32'd1);
    repeat (25) @(posedge clk);
    #1;
    chk("discarded shift", 32'(out_valid), 32'd0);
    do_op("add after reset", 4'h2, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (n % 3 == 0) b = b & 32'h7;
      if (n % 7 == 0) b = a;
      model(op, a, b, er, eill, elat);
      do_op($sformatf("rand%0d op%0h", n, op), op, a, b, er, eill, elat,
            int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Sequential execute-stage ALU with a valid/ready handshake. It sits directly downstream of the ALU controller and consumes its 4-bit `Operation` code, with operands from the register file and immediate mux. Logic, arithmetic, compare and branch-equality ops complete in one cycle. Shift ops use an iterative one-bit-per-cycle shifter, so latency depends on the data. The result is held until the writeback/branch logic accepts it.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_W`, default `$clog2(DATA_WIDTH)`: shift-amount width, taken from `SrcB[SHAMT_W-1:0]`.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operation/operands valid.
- `in_ready`  out  1  block can accept an operation.
- `Operation`  in  4  ALU operation code from the ALU controller.
- `SrcA`  in  DATA_WIDTH  operand A.
- `SrcB`  in  DATA_WIDTH  operand B or immediate.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `ALUResult`  out  DATA_WIDTH  registered result.
- `Zero`  out  1  high when `ALUResult` == 0.
- `illegal_op`  out  1  the accepted `Operation` was unassigned; qualified by `out_valid`.

## Operation
Operation codes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB (A−B).
- 0101 SLT: signed; result is {0…0, A<B}.
- 0110 SLL, 0111 SRL, 1001 SRA.
- 1000 BEQ: result is {0…0, A==B}.
- 1010–1111: result 0, `illegal_op`=1.

Arithmetic and shift rules:
- ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow outputs.
- Shift amount is `SrcB[SHAMT_W-1:0]`; upper bits of SrcB are ignored.
- SRA fills with `SrcA[DATA_WIDTH-1]` on every iteration.

State machine:
- States are IDLE, SHIFT and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&&in_ready`, capture `Operation`, SrcA and SrcB.
  - Non-shift op: compute the result into the result register and go to DONE.
  - Shift op with amount 0: result = SrcA; go to DONE.
  - Shift op with amount ≠ 0: load the shift register with SrcA and the counter with the amount; go to SHIFT.
- SHIFT:
  - Each cycle, shift the register by one bit in the captured direction and decrement the counter.
  - When the counter goes 1→0, the shifted value goes to the result register and the state goes to DONE.
  - `in_ready`=0.
- DONE:
  - `out_valid`=1; `ALUResult`, `Zero` and `illegal_op` are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0: no accept in the same cycle as result hand-off.
- `Zero` is derived from the result register, combinationally from that flop.

Boundary conditions:
- Inputs during SHIFT/DONE are ignored; nothing is captured.
- `out_ready` high while not in DONE has no effect.
- `out_valid` must not drop while in DONE until `out_ready` is seen (AXI-style hold).

Reset (`rst_n` low, any state, including mid-shift):
- Immediately: state=IDLE, counter=0, result=0, `out_valid`=0, `illegal_op`=0, `ALUResult`=0, `Zero`=1.
- `in_ready` is forced 0 while `rst_n` is low and is 1 from the first edge after release.
- An in-flight operation is discarded.

## Timing
- Accept at edge N:
  - Non-shift or shift-by-0: `out_valid` high after edge N+1.
  - Shift by k≥1: `out_valid` high after edge N+1+k. Maximum is N+DATA_WIDTH at k=DATA_WIDTH−1.
- Back-to-back throughput: one operation per (latency+1) cycles when `out_ready`=1.
- Combinational paths: the single-cycle ops are evaluated from captured-in-cycle inputs into the result register. No input-to-output combinational path exists except `rst_n` gating `in_ready`.

## Structure
- Package `alu_seq_pkg`:
  - `alu_op_e` enum with the 4-bit codes above.
  - `alu_state_e` enum for IDLE/SHIFT/DONE.
  - Helper constant `ALU_SHIFT_OPS`.
- Sub-module `alu_iter_shifter`:
  - Holds the shift register and down-counter, plus direction/arith-fill control.
  - Start/done pulses to the top FSM.
- The top level holds the FSM, capture registers and single-cycle datapath.

## Test plan
- ADD 5+7, `out_ready`=1 → `ALUResult`=12, `Zero`=0, `out_valid` exactly 1 cycle after accept; SUB 7−7 → 0, `Zero`=1.
- SLT A=0xFFFFFFFF, B=1 → 1; BEQ A=B=0x1234 → 1; BEQ A=1, B=2 → 0, `Zero`=1.
- SRA 0x80000000 by 4 → 0xF8000000 at accept+5; SRL same → 0x08000000; SLL 1 by 31 → 0x80000000 at accept+32; SLL by 0 → SrcA at accept+1.
- Hold `out_ready`=0 for 3 cycles after `out_valid` → result stable, `in_ready`=0, new `in_valid` ignored; release → IDLE next cycle.
- Assert `rst_n` low mid-SRL by 20 → `out_valid`=0, `ALUResult`=0, `Zero`=1, `in_ready`=0 at once; after release, ADD 1+1 → 2.
- `Operation`=1111 → `ALUResult`=0, `illegal_op`=1, latency 1 cycle.
